// File: rtl/ls_pkg.sv
// Shared load/store size encodings and the size-unit state enum.
// Also holds the alignment rule used by the load-side error check.
package ls_pkg;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;
   localparam logic [1:0] LS_INV  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      READ = 2'b01,
      DONE = 2'b10,
      ERR  = 2'b11
   } ls_state_e;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      if (size == LS_HALF) mis = addr_lo[0];
      else if (size == LS_WORD) mis = |addr_lo;
      return mis;
   endfunction

endpackage

// File: rtl/load_size_unit_if.sv
// Control-unit and memory-side signals of the load size unit.
// master = control unit plus memory model, slave = load_size_unit.
interface load_size_unit_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic              start;
   logic [1:0]        load_size_control;
   logic              sign_ext;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_read;
   logic [ADDR_W-1:0] mem_address;
   logic              busy;
   logic              done;
   logic              misaligned;
   logic              invalid_size;
   logic [DATA_W-1:0] load_size_out;

   modport master (
      output start, load_size_control, sign_ext, address, mem_data_in,
      input  mem_read, mem_address, busy, done, misaligned, invalid_size, load_size_out
   );

   modport slave (
      input  start, load_size_control, sign_ext, address, mem_data_in,
      output mem_read, mem_address, busy, done, misaligned, invalid_size, load_size_out
   );
endinterface

// File: rtl/load_extend.sv
// Narrows a memory word to byte/halfword/word from the low lanes,
// with zero- or sign-extension; size 11 passes the word through.
module load_extend
   import ls_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] word_i,
   input  logic [1:0]        size_i,
   input  logic              sign_ext_i,
   output logic [DATA_W-1:0] result_o
);

   always_comb begin
      result_o = word_i;
      unique case (size_i)
         LS_BYTE: result_o = {{(DATA_W-8){sign_ext_i & word_i[7]}}, word_i[7:0]};
         LS_HALF: result_o = {{(DATA_W-16){sign_ext_i & word_i[15]}}, word_i[15:0]};
         default: result_o = word_i;
      endcase
   end

endmodule

// File: rtl/load_size_unit.sv
// Multicycle load path: latches the request, drives the memory read for
// MEM_LATENCY cycles, then registers the size-extended result.
module load_size_unit
   import ls_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned MEM_LATENCY = 1
) (
   input logic             clk,
   input logic             reset,
   load_size_unit_if.slave bus
);

   localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

   ls_state_e         state_q;
   logic [2:0]        cnt_q;
   logic [1:0]        size_q;
   logic              sext_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] out_q;
   logic [DATA_W-1:0] ext;
   logic              mem_read_q, busy_q, done_q, mis_q, inv_q;

   // Fed from the latched size/sign, so only the sample edge sees mem_data_in.
   load_extend #(.DATA_W(DATA_W)) u_extend (
      .word_i    (bus.mem_data_in),
      .size_i    (size_q),
      .sign_ext_i(sext_q),
      .result_o  (ext)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         size_q     <= LS_BYTE;
         sext_q     <= 1'b0;
         addr_q     <= '0;
         out_q      <= '0;
         mem_read_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mis_q      <= 1'b0;
         inv_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         mis_q  <= 1'b0;
         inv_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  size_q <= bus.load_size_control;
                  sext_q <= bus.sign_ext;
                  addr_q <= bus.address;
                  busy_q <= 1'b1;
                  if (bus.load_size_control == LS_INV) begin
                     state_q <= ERR;
                     inv_q   <= 1'b1;
                  end else if (is_misaligned(bus.load_size_control, bus.address[1:0])) begin
                     state_q <= ERR;
                     mis_q   <= 1'b1;
                  end else begin
                     state_q    <= READ;
                     mem_read_q <= 1'b1;
                     cnt_q      <= CNT_INIT;
                  end
               end
            end
            READ: begin
               if (cnt_q == 3'd0) begin
                  out_q      <= ext;
                  mem_read_q <= 1'b0;
                  state_q    <= DONE;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            // done is registered here so it lands in the first IDLE cycle.
            DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            ERR: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_read      = mem_read_q;
   assign bus.mem_address   = addr_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.misaligned    = mis_q;
   assign bus.invalid_size  = inv_q;
   assign bus.load_size_out = out_q;

endmodule

// File: tb/tb_load_size_unit.sv
// Scoreboarded bench: two units (latency 1 and 3) share stimulus;
// expected responses are queued per unit and checked by a monitor.
module tb_load_size_unit;

   typedef struct packed {
      logic [1:0]  kind;   // 0 done, 1 misaligned, 2 invalid_size
      logic [31:0] val;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        start1 = 1'b0, start3 = 1'b0;
   logic [1:0]  size_r = 2'b00;
   logic        sext_r = 1'b0;
   logic [31:0] addr_r = 32'h0;
   logic [31:0] data_r = 32'h0;

   int total = 0;
   int bad = 0;
   int ndone1 = 0, ndone3 = 0;
   exp_t q1[$];
   exp_t q3[$];

   load_size_unit_if #(.DATA_W(32), .ADDR_W(32)) if1 ();
   load_size_unit_if #(.DATA_W(32), .ADDR_W(32)) if3 ();

   assign if1.start = start1;
   assign if3.start = start3;
   assign if1.load_size_control = size_r;
   assign if3.load_size_control = size_r;
   assign if1.sign_ext = sext_r;
   assign if3.sign_ext = sext_r;
   assign if1.address = addr_r;
   assign if3.address = addr_r;
   assign if1.mem_data_in = data_r;
   assign if3.mem_data_in = data_r;

   load_size_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(1)) dut1 (
      .clk  (clk),
      .reset(reset),
      .bus  (if1)
   );

   load_size_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LATENCY(3)) dut3 (
      .clk  (clk),
      .reset(reset),
      .bus  (if3)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   // Monitor: any flag or done must match the head of that unit's queue.
   always @(negedge clk) begin
      if (!reset) begin
         if (if1.done || if1.misaligned || if1.invalid_size) begin
            logic [1:0] k;
            exp_t e;
            k = if1.done ? 2'd0 : (if1.misaligned ? 2'd1 : 2'd2);
            if (if1.done) ndone1++;
            if (q1.size() == 0) begin
               check("lat1 unexpected response", {30'd0, k}, 32'hFFFFFFFF);
            end else begin
               e = q1.pop_front();
               check("lat1 response kind", {30'd0, k}, {30'd0, e.kind});
               check("lat1 load_size_out", if1.load_size_out, e.val);
            end
         end
         if (if3.done || if3.misaligned || if3.invalid_size) begin
            logic [1:0] k;
            exp_t e;
            k = if3.done ? 2'd0 : (if3.misaligned ? 2'd1 : 2'd2);
            if (if3.done) ndone3++;
            if (q3.size() == 0) begin
               check("lat3 unexpected response", {30'd0, k}, 32'hFFFFFFFF);
            end else begin
               e = q3.pop_front();
               check("lat3 response kind", {30'd0, k}, {30'd0, e.kind});
               check("lat3 load_size_out", if3.load_size_out, e.val);
            end
         end
      end
   end

   task automatic run_load(input bit l3, input logic [1:0] sz, input logic se,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] kind, input logic [31:0] exp, input bit chg);
      int lat, nrd, dk;
      bit addr_err;
      logic [31:0] bad_addr;
      exp_t e;
      lat = l3 ? 3 : 1;
      nrd = 0;
      dk = -1;
      addr_err = 1'b0;
      bad_addr = 32'h0;
      e.kind = kind;
      e.val = exp;
      @(negedge clk);
      size_r = sz;
      sext_r = se;
      addr_r = a;
      data_r = l3 ? 32'hxxxxxxxx : d;
      if (l3) begin
         start3 = 1'b1;
         q3.push_back(e);
      end else begin
         start1 = 1'b1;
         q1.push_back(e);
      end
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start3 = 1'b0;
      for (int k = 0; k < lat + 4; k++) begin
         logic rd, dn;
         logic [31:0] ma;
         @(negedge clk);
         rd = l3 ? if3.mem_read : if1.mem_read;
         dn = l3 ? if3.done : if1.done;
         ma = l3 ? if3.mem_address : if1.mem_address;
         if (rd) begin
            nrd++;
            if (ma !== a) begin
               addr_err = 1'b1;
               bad_addr = ma;
            end
         end
         if (dn && dk < 0) dk = k;
         if (chg && k == 0) addr_r = 32'h0000_0000;
         if (l3 && k == lat - 1) data_r = d;
         if (l3 && k == lat) data_r = 32'hxxxxxxxx;
      end
      check("mem_read cycles", 32'(nrd), (kind == 2'd0) ? 32'(lat) : 32'd0);
      check("done latency", 32'(dk), (kind == 2'd0) ? 32'(lat + 1) : 32'hFFFFFFFF);
      if (kind == 2'd0) check("mem_address held", addr_err ? bad_addr : a, a);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      #12;
      check("reset mem_read", {31'd0, if1.mem_read}, 32'd0);
      check("reset busy", {31'd0, if1.busy}, 32'd0);
      check("reset load_size_out", if1.load_size_out, 32'h0);
      check("reset mem_address", if3.mem_address, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // Latency 1: byte/halfword extraction variants.
      run_load(1'b0, 2'b00, 1'b1, 32'h100, 32'h1234_5680, 2'd0, 32'hFFFF_FF80, 1'b0);
      run_load(1'b0, 2'b00, 1'b0, 32'h103, 32'h1234_5680, 2'd0, 32'h0000_0080, 1'b0);
      run_load(1'b0, 2'b01, 1'b0, 32'h102, 32'hABCD_8001, 2'd0, 32'h0000_8001, 1'b0);
      run_load(1'b0, 2'b01, 1'b1, 32'h102, 32'hABCD_8001, 2'd0, 32'hFFFF_8001, 1'b0);
      run_load(1'b0, 2'b01, 1'b1, 32'h104, 32'h0001_7FFF, 2'd0, 32'h0000_7FFF, 1'b0);
      run_load(1'b0, 2'b10, 1'b1, 32'h108, 32'h8000_0000, 2'd0, 32'h8000_0000, 1'b0);
      run_load(1'b0, 2'b01, 1'b0, 32'h101, 32'h5555_5555, 2'd1, 32'h8000_0000, 1'b0);

      // Latency 3: word load with address changing mid-read, then errors.
      run_load(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEAD_BEEF, 2'd0, 32'hDEAD_BEEF, 1'b1);
      run_load(1'b1, 2'b10, 1'b0, 32'h202, 32'h1111_1111, 2'd1, 32'hDEAD_BEEF, 1'b0);
      run_load(1'b1, 2'b01, 1'b0, 32'h101, 32'h1111_1111, 2'd1, 32'hDEAD_BEEF, 1'b0);
      run_load(1'b1, 2'b11, 1'b0, 32'h100, 32'h1111_1111, 2'd2, 32'hDEAD_BEEF, 1'b0);

      // start held for 5 edges on latency 1: accepts at edges 0 and 3 only.
      d0 = ndone1;
      @(negedge clk);
      size_r = 2'b00;
      sext_r = 1'b0;
      addr_r = 32'h104;
      data_r = 32'h0000_00A5;
      q1.push_back('{kind: 2'd0, val: 32'h0000_00A5});
      q1.push_back('{kind: 2'd0, val: 32'h0000_00A5});
      start1 = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      start1 = 1'b0;
      repeat (5) @(negedge clk);
      check("held start done count", 32'(ndone1 - d0), 32'd2);
      check("held start queue drained", 32'(q1.size()), 32'd0);

      // Reset one cycle into a latency-3 read: no done afterwards.
      d0 = ndone3;
      @(negedge clk);
      size_r = 2'b10;
      addr_r = 32'h300;
      data_r = 32'h1111_1111;
      start3 = 1'b1;
      @(posedge clk);
      #1;
      start3 = 1'b0;
      @(negedge clk);
      check("pre-reset mem_read", {31'd0, if3.mem_read}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("async reset mem_read", {31'd0, if3.mem_read}, 32'd0);
      check("async reset busy", {31'd0, if3.busy}, 32'd0);
      check("async reset mem_address", if3.mem_address, 32'h0);
      check("async reset load_size_out", if3.load_size_out, 32'h0);
      check("async reset flags", {29'd0, if3.done, if3.misaligned, if3.invalid_size}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("no done after reset", 32'(ndone3 - d0), 32'd0);
      run_load(1'b1, 2'b10, 1'b0, 32'h204, 32'hCAFE_F00D, 2'd0, 32'hCAFE_F00D, 1'b0);
      repeat (2) @(negedge clk);
      check("lat1 queue empty", 32'(q1.size()), 32'd0);
      check("lat3 queue empty", 32'(q3.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
